// File: rtl/ethpipe_tx.sv
// GMII frame transmitter: reads a frame from the TX slot RAM, optionally waits for a launch
// time, then sends preamble/SFD, data, zero padding, FCS and the inter-frame gap.
module ethpipe_tx #(
    parameter logic [10:0] BASE_ADDR = 11'd2,
    parameter int unsigned IFG_BYTES = 12,
    parameter logic [11:0] MAX_LEN   = 12'd1514
) (
    input  logic        gmii_tx_clk,
    input  logic        sys_rst,
    input  logic [63:0] global_counter,
    input  logic        tx_start,
    input  logic [11:0] tx_frame_len,
    input  logic [63:0] tx_timestamp,
    output logic [10:0] slot_tx_eth_address,
    input  logic [31:0] slot_tx_eth_q,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        tx_busy,
    output logic        tx_done,
    output logic [63:0] tx_sent_timestamp
);

    typedef enum logic [2:0] {
        StIdle, StWaitTs, StPreamble, StData, StPad, StFcs, StIfg
    } state_e;

    state_e      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [11:0] len_q, len_d;
    logic [63:0] ts_q, ts_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  txd_q, txd_d;
    logic        tx_en_q, tx_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [63:0] sent_ts_q, sent_ts_d;
    logic [10:0] addr_q, addr_d;

    logic [7:0]  data_byte;
    logic [31:0] fcs_word;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    assign data_byte = slot_tx_eth_q[{cnt_q[1:0], 3'b000} +: 8];
    assign fcs_word  = ~crc_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        ts_d      = ts_q;
        crc_d     = crc_q;
        txd_d     = 8'h00;
        tx_en_d   = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sent_ts_d = sent_ts_q;
        addr_d    = addr_q;
        unique case (state_q)
            StIdle: begin
                if (tx_start) begin
                    len_d   = (tx_frame_len > MAX_LEN) ? MAX_LEN : tx_frame_len;
                    ts_d    = tx_timestamp;
                    busy_d  = 1'b1;
                    addr_d  = BASE_ADDR;
                    crc_d   = 32'hFFFFFFFF;
                    cnt_d   = 12'd0;
                    state_d = (tx_timestamp != 64'd0) ? StWaitTs : StPreamble;
                end
            end
            StWaitTs: begin
                if (global_counter >= ts_q) state_d = StPreamble;
            end
            StPreamble: begin
                tx_en_d = 1'b1;
                cnt_d   = cnt_q + 12'd1;
                if (cnt_q == 12'd7) begin
                    txd_d     = 8'hD5;
                    sent_ts_d = global_counter;
                    cnt_d     = 12'd0;
                    state_d   = (len_q == 12'd0) ? StPad : StData;
                end else begin
                    txd_d = 8'h55;
                end
            end
            StData: begin
                tx_en_d = 1'b1;
                txd_d   = data_byte;
                crc_d   = crc32_byte(crc_q, data_byte);
                cnt_d   = cnt_q + 12'd1;
                // Next word goes out while lane 2 is driven; the RAM output still holds
                // this word for lane 3, and the new word lands just in time for lane 0.
                if (cnt_q[1:0] == 2'd2) addr_d = BASE_ADDR + 11'(cnt_q[11:2]) + 11'd1;
                if (cnt_q == len_q - 12'd1) begin
                    if (len_q < 12'd60) begin
                        state_d = StPad;
                    end else begin
                        state_d = StFcs;
                        cnt_d   = 12'd0;
                    end
                end
            end
            StPad: begin
                tx_en_d = 1'b1;
                crc_d   = crc32_byte(crc_q, 8'h00);
                cnt_d   = cnt_q + 12'd1;
                if (cnt_q == 12'd59) begin
                    state_d = StFcs;
                    cnt_d   = 12'd0;
                end
            end
            StFcs: begin
                tx_en_d = 1'b1;
                txd_d   = fcs_word[{cnt_q[1:0], 3'b000} +: 8];
                cnt_d   = cnt_q + 12'd1;
                if (cnt_q == 12'd3) begin
                    state_d = StIfg;
                    cnt_d   = 12'd0;
                end
            end
            StIfg: begin
                cnt_d = cnt_q + 12'd1;
                if (cnt_q == 12'(IFG_BYTES - 1)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = 12'd0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge gmii_tx_clk) begin
        if (sys_rst) begin
            state_q   <= StIdle;
            cnt_q     <= 12'd0;
            len_q     <= 12'd0;
            ts_q      <= 64'd0;
            crc_q     <= 32'hFFFFFFFF;
            txd_q     <= 8'h00;
            tx_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sent_ts_q <= 64'd0;
            addr_q    <= BASE_ADDR;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            ts_q      <= ts_d;
            crc_q     <= crc_d;
            txd_q     <= txd_d;
            tx_en_q   <= tx_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sent_ts_q <= sent_ts_d;
            addr_q    <= addr_d;
        end
    end

    assign gmii_txd            = txd_q;
    assign gmii_tx_en          = tx_en_q;
    assign tx_busy             = busy_q;
    assign tx_done             = done_q;
    assign tx_sent_timestamp   = sent_ts_q;
    assign slot_tx_eth_address = addr_q;

endmodule

// File: tb/tb_ethpipe_tx.sv
// Scoreboard bench for ethpipe_tx: stimulus queues expected frames, a negedge monitor
// collects each tx_en burst and compares bytes, launch cycle, timestamp and IFG.
module tb_ethpipe_tx;

    localparam logic [10:0] BASE = 11'd2;
    localparam int          IFG  = 12;
    localparam int          MAXL = 1514;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic [63:0] gc = 64'd1000;
    logic        tx_start;
    logic [11:0] tx_frame_len;
    logic [63:0] tx_timestamp;
    logic [10:0] slot_addr;
    logic [31:0] slot_q;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic        tx_busy;
    logic        tx_done;
    logic [63:0] tx_sent_timestamp;

    int cyc = 0;
    logic [31:0] mem [0:2047];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        gc     <= gc + 64'd1;
        slot_q <= mem[slot_addr];
    end

    ethpipe_tx #(.BASE_ADDR(BASE), .IFG_BYTES(IFG), .MAX_LEN(12'd1514)) dut (
        .gmii_tx_clk        (clk),
        .sys_rst            (sys_rst),
        .global_counter     (gc),
        .tx_start           (tx_start),
        .tx_frame_len       (tx_frame_len),
        .tx_timestamp       (tx_timestamp),
        .slot_tx_eth_address(slot_addr),
        .slot_tx_eth_q      (slot_q),
        .gmii_txd           (gmii_txd),
        .gmii_tx_en         (gmii_tx_en),
        .tx_busy            (tx_busy),
        .tx_done            (tx_done),
        .tx_sent_timestamp  (tx_sent_timestamp)
    );

    typedef struct {
        int          nbytes;
        int          rise;
        logic [63:0] sent;
        bit          aborted;
        int          max_addr;
    } frame_t;

    frame_t     exp_q[$];
    logic [7:0] exp_bytes[$];
    int checks = 0;
    int passes = 0;
    int frames_sent = 0;
    int frames_seen = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, got, want, $time);
    endtask

    function automatic logic [31:0] crc_ref(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int b = 0; b < 8; b++) begin
            fb = c[0] ^ d[b];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    // Load RAM with byte n = n+seed, queue the expected frame, and issue tx_start.
    task automatic send(input int len, input logic [63:0] ts, input int seed,
                        input bit abort30, input bit now);
        int          l;
        int          pl;
        int          k;
        int          n;
        logic [63:0] g0;
        logic [31:0] crc;
        logic [7:0]  b;
        frame_t      f;
        for (int w = 0; w < 512; w++) begin
            for (int j = 0; j < 4; j++) mem[int'(BASE) + w][8*j +: 8] = 8'(4*w + j + seed);
        end
        l   = (len > MAXL) ? MAXL : len;
        pl  = (l < 60) ? 60 : l;
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < 7; i++) exp_bytes.push_back(8'h55);
        exp_bytes.push_back(8'hD5);
        for (int i = 0; i < pl; i++) begin
            b   = (i < l) ? 8'(i + seed) : 8'h00;
            crc = crc_ref(crc, b);
            if (!abort30 || i <= 30) exp_bytes.push_back(b);
        end
        if (!abort30) for (int j = 0; j < 4; j++) exp_bytes.push_back(~crc[8*j +: 8]);
        if (!now) @(negedge clk);
        g0 = gc;
        n  = cyc + 1;
        if (ts == 64'd0)     k = 0;
        else if (ts > g0 + 1) k = int'(ts - g0);
        else                 k = 1;
        f.nbytes   = abort30 ? 39 : 8 + pl + 4;
        f.rise     = n + k + 1;
        f.sent     = g0 + 64'(k) + 64'd8;
        f.aborted  = abort30;
        f.max_addr = (len >= MAXL) ? int'(BASE) + 378 : -1;
        exp_q.push_back(f);
        frames_sent++;
        tx_frame_len = 12'(len);
        tx_timestamp = ts;
        tx_start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (tx_done === 1'b1) found = 1'b1;
        end
        check("tx_done_within_budget", 64'(found), 64'd1);
    endtask

    // Monitor
    bit         in_frame = 1'b0;
    bit         after_frame = 1'b0;
    int         idle_cnt = 0;
    int         rise_cyc = 0;
    int         max_addr = 0;
    logic [7:0] got[$];

    task automatic end_frame();
        frame_t     f;
        int         mism;
        logic [7:0] e;
        frames_seen++;
        if (exp_q.size() == 0) begin
            check("unexpected_frame", 64'd1, 64'd0);
            return;
        end
        f = exp_q.pop_front();
        check("tx_en_length", 64'(got.size()), 64'(f.nbytes));
        check("launch_cycle", 64'(rise_cyc), 64'(f.rise));
        mism = 0;
        for (int i = 0; i < f.nbytes; i++) begin
            e = exp_bytes.pop_front();
            if (i >= got.size() || got[i] !== e) mism++;
        end
        check("frame_byte_mismatches", 64'(mism), 64'd0);
        if (f.max_addr >= 0) check("max_slot_address", 64'(max_addr), 64'(f.max_addr));
        if (!f.aborted) begin
            check("tx_sent_timestamp", tx_sent_timestamp, f.sent);
            after_frame = 1'b1;
            idle_cnt    = 1;
        end
    endtask

    always @(negedge clk) begin
        if (gmii_tx_en === 1'b1) begin
            if (!in_frame) begin
                in_frame = 1'b1;
                got.delete();
                rise_cyc = cyc;
                max_addr = 0;
            end
            got.push_back(gmii_txd);
            if (int'(slot_addr) > max_addr) max_addr = int'(slot_addr);
        end else if (in_frame) begin
            in_frame = 1'b0;
            end_frame();
        end else if (after_frame) begin
            idle_cnt++;
            if (tx_done === 1'b1) begin
                check("ifg_idle_cycles", 64'(idle_cnt), 64'(IFG));
                check("busy_low_at_done", 64'(tx_busy), 64'd0);
                after_frame = 1'b0;
            end
        end else if (tx_done === 1'b1) begin
            check("spurious_tx_done", 64'(tx_done), 64'd0);
        end
    end

    initial begin
        logic [63:0] ts;
        sys_rst      = 1'b1;
        tx_start     = 1'b0;
        tx_frame_len = 12'd0;
        tx_timestamp = 64'd0;
        repeat (3) @(negedge clk);
        check("rst_txd", 64'(gmii_txd), 64'd0);
        check("rst_tx_en", 64'(gmii_tx_en), 64'd0);
        check("rst_busy", 64'(tx_busy), 64'd0);
        check("rst_done", 64'(tx_done), 64'd0);
        check("rst_sent_ts", tx_sent_timestamp, 64'd0);
        check("rst_address", 64'(slot_addr), 64'(BASE));
        sys_rst = 1'b0;

        send(64, 64'd0, 0, 1'b0, 1'b0);
        wait_done(300);
        send(14, 64'd0, 8'h40, 1'b0, 1'b0);
        wait_done(300);

        @(negedge clk);
        ts = gc + 64'd100;
        send(64, ts, 8'h80, 1'b0, 1'b1);
        wait_done(400);
        send(64, 64'd1, 8'h13, 1'b0, 1'b0);
        wait_done(300);

        send(60, 64'd0, 7, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        tx_frame_len = 12'd5;
        tx_timestamp = 64'd0;
        tx_start     = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        check("busy_during_frame", 64'(tx_busy), 64'd1);
        wait_done(300);
        send(61, 64'd0, 9, 1'b0, 1'b1);
        wait_done(300);

        send(1514, 64'd0, 3, 1'b0, 1'b0);
        wait_done(2000);
        send(2000, 64'd0, 5, 1'b0, 1'b0);
        wait_done(2000);
        send(0, 64'd0, 1, 1'b0, 1'b0);
        wait_done(300);

        send(100, 64'd0, 8'h20, 1'b1, 1'b0);
        repeat (39) @(negedge clk);
        sys_rst = 1'b1;
        @(negedge clk);
        sys_rst = 1'b0;
        check("abort_tx_en", 64'(gmii_tx_en), 64'd0);
        check("abort_busy", 64'(tx_busy), 64'd0);
        repeat (30) @(negedge clk);
        send(64, 64'd0, 8'h11, 1'b0, 1'b0);
        wait_done(300);

        repeat (50) @(negedge clk);
        check("frames_seen", 64'(frames_seen), 64'(frames_sent));
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ethpipe_tx.md
# ethpipe_tx

Ethernet frame transmitter for the ethpipe core: the transmit-side counterpart of the GMII receive path. It reads one frame from the TX frame slot RAM (32-bit words, byte-lane addressed), optionally waits for a launch time on the global counter, and drives it onto GMII with preamble/SFD. It pads short frames to the Ethernet minimum, appends the FCS, enforces the inter-frame gap, and reports completion plus the actual launch timestamp.

## Interface
- BASE_ADDR, 11'd2, slot word address of frame byte 0
- IFG_BYTES, 12, idle cycles after the last FCS byte
- MAX_LEN, 12'd1514, longest frame in bytes (excluding FCS)
- gmii_tx_clk  in  1  sole clock; all logic on its rising edge
- sys_rst  in  1  synchronous, active-high reset
- global_counter  in  64  free-running timestamp counter (same clock domain)
- tx_start  in  1  single-cycle request, already synchronized to gmii_tx_clk
- tx_frame_len  in  12  frame length in bytes, no preamble/FCS; sampled on accept
- tx_timestamp  in  64  launch time; 0 = immediate; sampled on accept
- slot_tx_eth_address  out  11  slot RAM word address
- slot_tx_eth_q  in  32  slot RAM read data, valid 1 cycle after address; byte n of word in bits [8n+7:8n]
- gmii_txd  out  8  GMII transmit data
- gmii_tx_en  out  1  GMII transmit enable
- tx_busy  out  1  high from accept through end of IFG
- tx_done  out  1  one-cycle pulse at end of IFG
- tx_sent_timestamp  out  64  global_counter value when SFD is driven

## Operation
- States: IDLE, WAIT_TS, PREAMBLE, DATA, PAD, FCS, IFG.
- IDLE: tx_start=1 accepts; latches length and timestamp; tx_busy<=1. Next state is WAIT_TS if the latched timestamp is non-zero, else PREAMBLE.
- WAIT_TS: stay until global_counter >= latched timestamp (64-bit unsigned), then PREAMBLE. A timestamp already in the past launches at once.
- PREAMBLE: 8 bytes, 0x55 x7 then 0xD5; tx_en=1. On the 0xD5 cycle, capture global_counter into tx_sent_timestamp.
- DATA: bytes 0..L-1, where L = min(len, MAX_LEN). Byte n is read from word BASE_ADDR + n[11:2], lane n[1:0].
  - Word k+1 is addressed at least 2 cycles before its first byte is driven, so read latency never stalls the stream.
  - The first word is fetched during PREAMBLE.
- PAD: if L < 60, drive 0x00 until 60 bytes have been sent; pad bytes are included in the CRC.
- FCS: 4 bytes of ~crc, LSB byte first.
  - CRC-32: reflected polynomial 0xEDB88320, init 0xFFFFFFFF.
  - Covers the data and pad bytes only, not the preamble/SFD.
- IFG: tx_en=0, txd=0x00 for IFG_BYTES cycles. On the last cycle: tx_done=1, tx_busy<=0, then IDLE.
- tx_start while tx_busy=1 is ignored, with no queueing.
- len=0 sends a frame of 60 pad bytes plus FCS.
- len>MAX_LEN is truncated to MAX_LEN.

## Timing
- Reset values:
  - gmii_txd=0, gmii_tx_en=0, tx_busy=0, tx_done=0
  - tx_sent_timestamp=0, slot_tx_eth_address=BASE_ADDR
  - state IDLE, CRC=0xFFFFFFFF
- Reset mid-frame: tx_en drops on the next edge; no FCS or IFG is sent; no tx_done pulse.
- All GMII outputs are registered.
- Immediate launch: with accept at edge N, the first 0x55 is driven after edge N+1.
  - SFD after edge N+8.
  - Data byte 0 after edge N+9.
- tx_en stays continuously high for 8 + max(L,60) + 4 cycles, with no gaps.
- WAIT_TS launch: with the compare true at edge M, the first 0x55 is driven after edge M+1.
- Minimum start-to-start spacing: 1 + 8 + max(L,60) + 4 + IFG_BYTES cycles. tx_start on the cycle after tx_done is accepted.

## Test plan
- Immediate 64-byte frame, bytes 0x00..0x3F, timestamp=0. Expect:
  - 55x7, D5, then 64 data bytes in order.
  - FCS matching the reference CRC-32 model.
  - tx_en high for 76 cycles, then 12 idle cycles, then a tx_done pulse.
- Short frame, len=14. Expect 14 data bytes, 46 bytes of 0x00, and an FCS computed over all 60 bytes; tx_en high for 72 cycles.
- Scheduled launch, timestamp = global_counter+100 at accept. Expect:
  - SFD no earlier than counter ≥ timestamp+7.
  - tx_sent_timestamp equals the counter value on the SFD cycle.
  - A past timestamp (e.g. 1) launches immediately.
- Back-to-back: a tx_start pulse during busy is ignored. tx_start on the cycle after tx_done starts the next frame with exactly 12 idle cycles between tx_en periods.
- Length extremes: len=1514 sends 1514 bytes plus FCS from words BASE_ADDR..BASE_ADDR+378; len=2000 sends 1514 bytes; len=0 sends 60 zero bytes.
- sys_rst asserted at data byte 30. Expect tx_en=0 and tx_busy=0 after the next edge, no tx_done, and a clean frame on the following tx_start.
